// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the control-word pipeline and its hazard unit.
package ctrl_pipe_pkg;

    localparam int STALL_CNT_W_DEF = 16;
    localparam int REG_W           = 5;

    // ALU operation codes carried in the control word
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // Operand forwarding source for the EX-stage ALU
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_WB   = 2'd1,
        FWD_MEM  = 2'd2
    } fwd_sel_e;

    // Control word as produced by Control_Unit in ID
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_op;
    } ctrl_word_t;

    localparam int         CTRL_W      = $bits(ctrl_word_t);
    localparam ctrl_word_t CTRL_BUBBLE = ctrl_word_t'({CTRL_W{1'b0}});

    // Pick the youngest later-stage producer of src; $0 is hard-wired and never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic             mem_wr,
        input logic [REG_W-1:0] mem_reg,
        input logic             wb_wr,
        input logic [REG_W-1:0] wb_reg,
        input logic [REG_W-1:0] src
    );
        fwd_sel_e sel;
        if (mem_wr && (mem_reg != 5'd0) && (mem_reg == src)) begin
            sel = FWD_MEM;
        end else if (wb_wr && (wb_reg != 5'd0) && (wb_reg == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle of the ID-stage control word, EX flag and per-stage control outputs.
interface ctrl_pipe_if
    import ctrl_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
);
    // ID stage inputs
    logic                   RegDst;
    logic                   Branch;
    logic                   MemRead;
    logic                   MemtoReg;
    logic                   MemWrite;
    logic                   ALUSrc;
    logic                   RegWrite;
    logic [3:0]             ALUOp;
    logic [REG_W-1:0]       Id_Rs;
    logic [REG_W-1:0]       Id_Rt;
    logic [REG_W-1:0]       Id_Rd;
    logic                   Zero;

    // Per-stage outputs
    logic                   Ex_ALUSrc;
    logic [3:0]             Ex_ALUOp;
    logic [1:0]             ForwardA;
    logic [1:0]             ForwardB;
    logic                   Mem_MemRead;
    logic                   Mem_MemWrite;
    logic                   Wb_RegWrite;
    logic                   Wb_MemtoReg;
    logic [REG_W-1:0]       Wb_WriteReg;
    logic                   Stall;
    logic                   Flush;
    logic [STALL_CNT_W-1:0] StallCount;

    // Datapath side: drives the control word, consumes the stage controls
    modport master (
        output RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
        output ALUOp, Id_Rs, Id_Rt, Id_Rd, Zero,
        input  Ex_ALUSrc, Ex_ALUOp, ForwardA, ForwardB, Mem_MemRead, Mem_MemWrite,
        input  Wb_RegWrite, Wb_MemtoReg, Wb_WriteReg, Stall, Flush, StallCount
    );

    // Pipeline carrier side
    modport slave (
        input  RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
        input  ALUOp, Id_Rs, Id_Rt, Id_Rd, Zero,
        output Ex_ALUSrc, Ex_ALUOp, ForwardA, ForwardB, Mem_MemRead, Mem_MemWrite,
        output Wb_RegWrite, Wb_MemtoReg, Wb_WriteReg, Stall, Flush, StallCount
    );

endinterface

// File: rtl/ctrl_pipe_hazard_detect.sv
// Combinational load-use / taken-branch detection and EX operand forwarding selects.
module hazard_detect
    import ctrl_pipe_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic             ex_branch,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             zero,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_write_reg,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_write_reg,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b
);

    logic load_use_s;
    logic taken_s;

    // Classify the cycle; a taken branch squashes ID, so any load-use stall is moot.
    always_comb begin
        load_use_s = 1'b0;
        taken_s    = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        if (ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
        if (ex_branch && zero) begin
            taken_s = 1'b1;
        end else begin
            taken_s = 1'b0;
        end
        if (taken_s) begin
            flush = 1'b1;
            stall = 1'b0;
        end else begin
            flush = 1'b0;
            stall = load_use_s;
        end
    end

    // Forwarding selects for both EX operands, EX/MEM taking precedence over MEM/WB.
    always_comb begin
        forward_a = fwd_select(mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg, ex_rs);
        forward_b = fwd_select(mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg, ex_rt);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the ID control word through ID/EX, EX/MEM and MEM/WB and counts stall/flush cycles.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
)
(
    input  logic       Clk,
    input  logic       Rst_n,
    ctrl_pipe_if.slave bus
);

    localparam logic [STALL_CNT_W-1:0] CNT_ZERO = {STALL_CNT_W{1'b0}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};

    ctrl_word_t             id_ctrl_s;
    ctrl_word_t             ex_ctrl_d_s;
    logic [REG_W-1:0]       ex_rs_d_s;
    logic [REG_W-1:0]       ex_rt_d_s;
    logic [REG_W-1:0]       ex_rd_d_s;
    logic [REG_W-1:0]       ex_write_reg_s;

    // ID/EX
    ctrl_word_t             ex_ctrl_r;
    logic [REG_W-1:0]       ex_rs_r;
    logic [REG_W-1:0]       ex_rt_r;
    logic [REG_W-1:0]       ex_rd_r;
    // EX/MEM
    logic                   mem_mem_read_r;
    logic                   mem_mem_write_r;
    logic                   mem_mem_to_reg_r;
    logic                   mem_reg_write_r;
    logic [REG_W-1:0]       mem_write_reg_r;
    // MEM/WB
    logic                   wb_reg_write_r;
    logic                   wb_mem_to_reg_r;
    logic [REG_W-1:0]       wb_write_reg_r;

    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   stall_s;
    logic                   flush_s;
    logic [1:0]             fwd_a_s;
    logic [1:0]             fwd_b_s;

    hazard_detect u_hazard (
        .ex_mem_read   (ex_ctrl_r.mem_read),
        .ex_branch     (ex_ctrl_r.branch),
        .ex_rs         (ex_rs_r),
        .ex_rt         (ex_rt_r),
        .id_rs         (bus.Id_Rs),
        .id_rt         (bus.Id_Rt),
        .zero          (bus.Zero),
        .mem_reg_write (mem_reg_write_r),
        .mem_write_reg (mem_write_reg_r),
        .wb_reg_write  (wb_reg_write_r),
        .wb_write_reg  (wb_write_reg_r),
        .stall         (stall_s),
        .flush         (flush_s),
        .forward_a     (fwd_a_s),
        .forward_b     (fwd_b_s)
    );

    // Pack the ID control word and choose what ID/EX loads: the instruction or a bubble.
    always_comb begin
        id_ctrl_s            = CTRL_BUBBLE;
        id_ctrl_s.reg_dst    = bus.RegDst;
        id_ctrl_s.branch     = bus.Branch;
        id_ctrl_s.mem_read   = bus.MemRead;
        id_ctrl_s.mem_to_reg = bus.MemtoReg;
        id_ctrl_s.mem_write  = bus.MemWrite;
        id_ctrl_s.alu_src    = bus.ALUSrc;
        id_ctrl_s.reg_write  = bus.RegWrite;
        id_ctrl_s.alu_op     = bus.ALUOp;
        ex_ctrl_d_s          = CTRL_BUBBLE;
        ex_rs_d_s            = 5'd0;
        ex_rt_d_s            = 5'd0;
        ex_rd_d_s            = 5'd0;
        if (stall_s || flush_s) begin
            ex_ctrl_d_s = CTRL_BUBBLE;
            ex_rs_d_s   = 5'd0;
            ex_rt_d_s   = 5'd0;
            ex_rd_d_s   = 5'd0;
        end else begin
            ex_ctrl_d_s = id_ctrl_s;
            ex_rs_d_s   = bus.Id_Rs;
            ex_rt_d_s   = bus.Id_Rt;
            ex_rd_d_s   = bus.Id_Rd;
        end
    end

    // Destination register is resolved in EX from RegDst.
    always_comb begin
        if (ex_ctrl_r.reg_dst) begin
            ex_write_reg_s = ex_rd_r;
        end else begin
            ex_write_reg_s = ex_rt_r;
        end
    end

    // ID/EX register; reset empties the stage immediately.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_ctrl_r <= CTRL_BUBBLE;
            ex_rs_r   <= 5'd0;
            ex_rt_r   <= 5'd0;
            ex_rd_r   <= 5'd0;
        end else begin
            ex_ctrl_r <= ex_ctrl_d_s;
            ex_rs_r   <= ex_rs_d_s;
            ex_rt_r   <= ex_rt_d_s;
            ex_rd_r   <= ex_rd_d_s;
        end
    end

    // EX/MEM and MEM/WB always advance, even while ID is stalled.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mem_mem_read_r   <= 1'b0;
            mem_mem_write_r  <= 1'b0;
            mem_mem_to_reg_r <= 1'b0;
            mem_reg_write_r  <= 1'b0;
            mem_write_reg_r  <= 5'd0;
            wb_reg_write_r   <= 1'b0;
            wb_mem_to_reg_r  <= 1'b0;
            wb_write_reg_r   <= 5'd0;
        end else begin
            mem_mem_read_r   <= ex_ctrl_r.mem_read;
            mem_mem_write_r  <= ex_ctrl_r.mem_write;
            mem_mem_to_reg_r <= ex_ctrl_r.mem_to_reg;
            mem_reg_write_r  <= ex_ctrl_r.reg_write;
            mem_write_reg_r  <= ex_write_reg_s;
            wb_reg_write_r   <= mem_reg_write_r;
            wb_mem_to_reg_r  <= mem_mem_to_reg_r;
            wb_write_reg_r   <= mem_write_reg_r;
        end
    end

    // Saturating count of cycles lost to a stall or a flush.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_r <= CNT_ZERO;
        end else if ((stall_s || flush_s) && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.Ex_ALUSrc    = ex_ctrl_r.alu_src;
    assign bus.Ex_ALUOp     = ex_ctrl_r.alu_op;
    assign bus.ForwardA     = fwd_a_s;
    assign bus.ForwardB     = fwd_b_s;
    assign bus.Mem_MemRead  = mem_mem_read_r;
    assign bus.Mem_MemWrite = mem_mem_write_r;
    assign bus.Wb_RegWrite  = wb_reg_write_r;
    assign bus.Wb_MemtoReg  = wb_mem_to_reg_r;
    assign bus.Wb_WriteReg  = wb_write_reg_r;
    assign bus.Stall        = stall_s;
    assign bus.Flush        = flush_s;
    assign bus.StallCount   = stall_cnt_r;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed vector table, reset/latency and
// saturation sequences, then random instruction streams against a pipeline model.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    typedef struct packed {
        logic       regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite;
        logic [3:0] aluop;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct packed {
        instr_t     id;
        logic       zero;
        logic       stall, flush;
        logic [1:0] fa, fb;
        logic [3:0] ex_aluop;
        logic       mem_read, wb_rw;
        logic [4:0] wb_wr;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 20;

    logic Clk = 1'b0;
    logic Rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [NV];

    always #5 Clk = ~Clk;

    ctrl_pipe_if #(.STALL_CNT_W(16)) bus ();
    ctrl_pipe_if #(.STALL_CNT_W(2))  bus2 ();

    ctrl_pipe #(.STALL_CNT_W(16)) dut     (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
    ctrl_pipe #(.STALL_CNT_W(2))  dut_sat (.Clk(Clk), .Rst_n(Rst_n), .bus(bus2));

    function automatic instr_t f_nop();
        instr_t r = '0;
        return r;
    endfunction
    function automatic instr_t f_lw(input logic [4:0] t, input logic [4:0] s);
        instr_t r = '0;
        r.memread = 1'b1; r.memtoreg = 1'b1; r.alusrc = 1'b1; r.regwrite = 1'b1;
        r.aluop = ALU_ADD; r.rt = t; r.rs = s;
        return r;
    endfunction
    function automatic instr_t f_rtype(input logic [3:0] op, input logic [4:0] d,
                                       input logic [4:0] s, input logic [4:0] t);
        instr_t r = '0;
        r.regdst = 1'b1; r.regwrite = 1'b1; r.aluop = op; r.rd = d; r.rs = s; r.rt = t;
        return r;
    endfunction
    function automatic instr_t f_addi(input logic [4:0] t, input logic [4:0] s);
        instr_t r = '0;
        r.alusrc = 1'b1; r.regwrite = 1'b1; r.aluop = ALU_ADD; r.rt = t; r.rs = s;
        return r;
    endfunction
    // Branch word that also carries MemRead, so a load-use match coexists with the branch
    function automatic instr_t f_bx(input logic [4:0] s, input logic [4:0] t);
        instr_t r = '0;
        r.branch = 1'b1; r.memread = 1'b1; r.aluop = ALU_SUB; r.rs = s; r.rt = t;
        return r;
    endfunction
    function automatic instr_t f_rand();
        instr_t r;
        r.regdst = 1'($urandom_range(0, 1)); r.branch   = 1'($urandom_range(0, 1));
        r.memread = 1'($urandom_range(0, 1)); r.memtoreg = 1'($urandom_range(0, 1));
        r.memwrite = 1'($urandom_range(0, 1)); r.alusrc = 1'($urandom_range(0, 1));
        r.regwrite = 1'($urandom_range(0, 1)); r.aluop  = 4'($urandom_range(0, 15));
        r.rs = 5'($urandom_range(0, 3)); r.rt = 5'($urandom_range(0, 3));
        r.rd = 5'($urandom_range(0, 3));
        return r;
    endfunction

    function automatic vec_t mkv(input instr_t id, input logic z, input logic st, input logic fl,
                                 input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] op,
                                 input logic mr, input logic rw, input logic [4:0] wr,
                                 input logic [15:0] cnt);
        vec_t v;
        v.id = id; v.zero = z; v.stall = st; v.flush = fl; v.fa = fa; v.fb = fb;
        v.ex_aluop = op; v.mem_read = mr; v.wb_rw = rw; v.wb_wr = wr; v.cnt = cnt;
        return v;
    endfunction

    // Model helpers: destination and forwarding derived from stage contents
    function automatic logic [4:0] m_dest(input instr_t i);
        return i.regdst ? i.rd : i.rt;
    endfunction
    function automatic logic [1:0] m_fwd(input instr_t m, input instr_t w, input logic [4:0] src);
        if (m.regwrite && m_dest(m) != 5'd0 && m_dest(m) == src) return 2'd2;
        if (w.regwrite && m_dest(w) != 5'd0 && m_dest(w) == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic drive(input instr_t i, input logic z);
        bus.RegDst = i.regdst; bus.Branch = i.branch; bus.MemRead = i.memread;
        bus.MemtoReg = i.memtoreg; bus.MemWrite = i.memwrite; bus.ALUSrc = i.alusrc;
        bus.RegWrite = i.regwrite; bus.ALUOp = i.aluop;
        bus.Id_Rs = i.rs; bus.Id_Rt = i.rt; bus.Id_Rd = i.rd; bus.Zero = z;
    endtask
    task automatic drive2(input instr_t i, input logic z);
        bus2.RegDst = i.regdst; bus2.Branch = i.branch; bus2.MemRead = i.memread;
        bus2.MemtoReg = i.memtoreg; bus2.MemWrite = i.memwrite; bus2.ALUSrc = i.alusrc;
        bus2.RegWrite = i.regwrite; bus2.ALUOp = i.aluop;
        bus2.Id_Rs = i.rs; bus2.Id_Rt = i.rt; bus2.Id_Rd = i.rd; bus2.Zero = z;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_alusrc"}, 32'(bus.Ex_ALUSrc), 32'd0);
        check({tag, "_ex_aluop"},  32'(bus.Ex_ALUOp), 32'd0);
        check({tag, "_fwd_a"},     32'(bus.ForwardA), 32'd0);
        check({tag, "_fwd_b"},     32'(bus.ForwardB), 32'd0);
        check({tag, "_mem_rd"},    32'(bus.Mem_MemRead), 32'd0);
        check({tag, "_mem_wr"},    32'(bus.Mem_MemWrite), 32'd0);
        check({tag, "_wb_rw"},     32'(bus.Wb_RegWrite), 32'd0);
        check({tag, "_wb_m2r"},    32'(bus.Wb_MemtoReg), 32'd0);
        check({tag, "_wb_wr"},     32'(bus.Wb_WriteReg), 32'd0);
        check({tag, "_stall"},     32'(bus.Stall), 32'd0);
        check({tag, "_flush"},     32'(bus.Flush), 32'd0);
        check({tag, "_cnt"},       32'(bus.StallCount), 32'd0);
        check({tag, "_sat_cnt"},   32'(bus2.StallCount), 32'd0);
    endtask

    initial begin
        instr_t m_ex, m_mem, m_wb, cur, br;
        int     m_cnt;
        logic   z, lu, e_stall, e_flush, hold;

        // Directed table: one record per ID cycle, outputs observed before the edge
        vecs[0]  = mkv(f_lw(5'd5, 5'd1),                     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0,    1'b0, 1'b0, 5'd0,  16'd0);
        vecs[1]  = mkv(f_rtype(ALU_ADD, 5'd6, 5'd5, 5'd2),   1'b0, 1'b1, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b0, 5'd0,  16'd0);
        vecs[2]  = mkv(f_rtype(ALU_ADD, 5'd6, 5'd5, 5'd2),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0,    1'b1, 1'b0, 5'd0,  16'd1);
        vecs[3]  = mkv(f_nop(),                              1'b0, 1'b0, 1'b0, 2'd1, 2'd0, ALU_ADD, 1'b0, 1'b1, 5'd5,  16'd1);
        vecs[4]  = mkv(f_rtype(ALU_ADD, 5'd3, 5'd1, 5'd2),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0,    1'b0, 1'b0, 5'd0,  16'd1);
        vecs[5]  = mkv(f_rtype(ALU_ADD, 5'd3, 5'd4, 5'd4),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b1, 5'd6,  16'd1);
        vecs[6]  = mkv(f_rtype(ALU_SUB, 5'd7, 5'd3, 5'd3),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b0, 5'd0,  16'd1);
        vecs[7]  = mkv(f_nop(),                              1'b0, 1'b0, 1'b0, 2'd2, 2'd2, ALU_SUB, 1'b0, 1'b1, 5'd3,  16'd1);
        vecs[8]  = mkv(f_lw(5'd0, 5'd1),                     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0,    1'b0, 1'b1, 5'd3,  16'd1);
        vecs[9]  = mkv(f_rtype(ALU_ADD, 5'd8, 5'd0, 5'd0),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b1, 5'd7,  16'd1);
        vecs[10] = mkv(f_addi(5'd0, 5'd2),                   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b1, 1'b0, 5'd0,  16'd1);
        vecs[11] = mkv(f_rtype(ALU_ADD, 5'd9, 5'd0, 5'd0),   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b1, 5'd0,  16'd1);
        vecs[12] = mkv(f_nop(),                              1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b1, 5'd8,  16'd1);
        vecs[13] = mkv(f_bx(5'd4, 5'd4),                     1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0,    1'b0, 1'b1, 5'd0,  16'd1);
        vecs[14] = mkv(f_rtype(ALU_ADD, 5'd10, 5'd4, 5'd4),  1'b1, 1'b0, 1'b1, 2'd0, 2'd0, ALU_SUB, 1'b0, 1'b1, 5'd9,  16'd1);
        vecs[15] = mkv(f_rtype(ALU_ADD, 5'd11, 5'd1, 5'd1),  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0,    1'b1, 1'b0, 5'd0,  16'd2);
        vecs[16] = mkv(f_bx(5'd4, 5'd4),                     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b0, 5'd4,  16'd2);
        vecs[17] = mkv(f_rtype(ALU_ADD, 5'd10, 5'd4, 5'd4),  1'b0, 1'b1, 1'b0, 2'd0, 2'd0, ALU_SUB, 1'b0, 1'b0, 5'd0,  16'd2);
        vecs[18] = mkv(f_rtype(ALU_ADD, 5'd10, 5'd4, 5'd4),  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0,    1'b1, 1'b1, 5'd11, 16'd3);
        vecs[19] = mkv(f_nop(),                              1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b0, 5'd4,  16'd3);

        // Power-on reset
        Rst_n = 1'b0;
        drive(f_nop(), 1'b0);
        drive2(f_nop(), 1'b0);
        #12;
        check_all_zero("por");
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].id, vecs[i].zero);
            #1;
            check($sformatf("tbl%0d_stall", i), 32'(bus.Stall),       32'(vecs[i].stall));
            check($sformatf("tbl%0d_flush", i), 32'(bus.Flush),       32'(vecs[i].flush));
            check($sformatf("tbl%0d_fwd_a", i), 32'(bus.ForwardA),    32'(vecs[i].fa));
            check($sformatf("tbl%0d_fwd_b", i), 32'(bus.ForwardB),    32'(vecs[i].fb));
            check($sformatf("tbl%0d_aluop", i), 32'(bus.Ex_ALUOp),    32'(vecs[i].ex_aluop));
            check($sformatf("tbl%0d_memrd", i), 32'(bus.Mem_MemRead), 32'(vecs[i].mem_read));
            check($sformatf("tbl%0d_wb_rw", i), 32'(bus.Wb_RegWrite), 32'(vecs[i].wb_rw));
            check($sformatf("tbl%0d_wb_wr", i), 32'(bus.Wb_WriteReg), 32'(vecs[i].wb_wr));
            check($sformatf("tbl%0d_cnt", i),   32'(bus.StallCount),  32'(vecs[i].cnt));
            @(posedge Clk);
            #1;
        end

        // Mid-stream reset: ADD $10 is in flight in MEM and must vanish at once
        Rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge Clk);
        Rst_n = 1'b1;
        drive(f_rtype(ALU_ADD, 5'd3, 5'd1, 5'd2), 1'b0);
        @(posedge Clk);
        #1;
        drive(f_nop(), 1'b0);
        check("lat_e1_aluop", 32'(bus.Ex_ALUOp), 32'(ALU_ADD));
        check("lat_e1_wb_rw", 32'(bus.Wb_RegWrite), 32'd0);
        @(posedge Clk);
        #1;
        check("lat_e2_wb_rw", 32'(bus.Wb_RegWrite), 32'd0);
        @(posedge Clk);
        #1;
        check("lat_e3_wb_rw", 32'(bus.Wb_RegWrite), 32'd1);
        check("lat_e3_wb_wr", 32'(bus.Wb_WriteReg), 32'd3);

        // Random stream against the stage-by-stage instruction model
        m_ex  = f_nop();
        m_mem = f_nop();
        m_wb  = f_rtype(ALU_ADD, 5'd3, 5'd1, 5'd2);
        m_cnt = 0;
        hold  = 1'b0;
        cur   = f_nop();
        for (int c = 0; c < 400; c++) begin
            if (!hold) cur = f_rand();
            z = 1'($urandom_range(0, 1));
            drive(cur, z);
            #1;
            e_flush = m_ex.branch && z;
            lu      = m_ex.memread && (m_ex.rt != 5'd0) && (m_ex.rt == cur.rs || m_ex.rt == cur.rt);
            e_stall = lu && !e_flush;
            check($sformatf("rnd%0d_stall", c),  32'(bus.Stall),        32'(e_stall));
            check($sformatf("rnd%0d_flush", c),  32'(bus.Flush),        32'(e_flush));
            check($sformatf("rnd%0d_fwd_a", c),  32'(bus.ForwardA),     32'(m_fwd(m_mem, m_wb, m_ex.rs)));
            check($sformatf("rnd%0d_fwd_b", c),  32'(bus.ForwardB),     32'(m_fwd(m_mem, m_wb, m_ex.rt)));
            check($sformatf("rnd%0d_alusrc", c), 32'(bus.Ex_ALUSrc),    32'(m_ex.alusrc));
            check($sformatf("rnd%0d_aluop", c),  32'(bus.Ex_ALUOp),     32'(m_ex.aluop));
            check($sformatf("rnd%0d_memrd", c),  32'(bus.Mem_MemRead),  32'(m_mem.memread));
            check($sformatf("rnd%0d_memwr", c),  32'(bus.Mem_MemWrite), 32'(m_mem.memwrite));
            check($sformatf("rnd%0d_wb_rw", c),  32'(bus.Wb_RegWrite),  32'(m_wb.regwrite));
            check($sformatf("rnd%0d_wb_m2r", c), 32'(bus.Wb_MemtoReg),  32'(m_wb.memtoreg));
            check($sformatf("rnd%0d_wb_wr", c),  32'(bus.Wb_WriteReg),  32'(m_dest(m_wb)));
            check($sformatf("rnd%0d_cnt", c),    32'(bus.StallCount),   32'(m_cnt));
            @(posedge Clk);
            #1;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (e_stall || e_flush) ? f_nop() : cur;
            if ((e_stall || e_flush) && m_cnt < 65535) m_cnt = m_cnt + 1;
            hold = e_stall;
        end

        // Saturation on the 2-bit counter: a taken branch in EX every other cycle
        br = '0;
        br.branch = 1'b1;
        br.aluop  = ALU_SUB;
        drive2(br, 1'b1);
        @(posedge Clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("sat%0d_flush", k), 32'(bus2.Flush), 32'((k % 2) == 0));
            check($sformatf("sat%0d_stall", k), 32'(bus2.Stall), 32'd0);
            check($sformatf("sat%0d_cnt", k),   32'(bus2.StallCount),
                  32'(((k + 1) / 2) > 3 ? 3 : ((k + 1) / 2)));
            @(posedge Clk);
            #1;
        end
        check("sat_final_cnt", 32'(bus2.StallCount), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipeline carrier and hazard unit for the control word leaving `Control_Unit` in the ID stage. It registers the control word and the register specifiers through ID/EX, EX/MEM and MEM/WB, and delivers each field to the stage that consumes it. It also detects load-use hazards, flushes on taken branches, and generates forwarding selects for the EX-stage ALU operands.

## Interface
Parameters:
- `STALL_CNT_W`, 16: width of the saturating stall/flush performance counter.

Ports:
- `Clk`  in  1  pipeline clock; all state updates on rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite`  in  1 each  ID-stage control word.
- `ALUOp`  in  4  ID-stage ALU operation code.
- `Id_Rs, Id_Rt, Id_Rd`  in  5 each  register fields of the instruction in ID.
- `Zero`  in  1  ALU zero flag for the instruction in EX.
- `Ex_ALUSrc`  out  1  EX operand-B select.
- `Ex_ALUOp`  out  4  EX ALU operation.
- `ForwardA, ForwardB`  out  2 each  EX operand forwarding selects.
- `Mem_MemRead, Mem_MemWrite`  out  1 each  data-memory strobes.
- `Wb_RegWrite, Wb_MemtoReg`  out  1 each  writeback controls.
- `Wb_WriteReg`  out  5  writeback destination register.
- `Stall`  out  1  hold PC and IF/ID this cycle.
- `Flush`  out  1  squash IF/ID this cycle.
- `StallCount`  out  STALL_CNT_W  saturating count of cycles in which `Stall` or `Flush` was asserted.

## Operation
- Destination register is computed in EX as `RegDst ? Rd : Rt` and carried in EX/MEM and MEM/WB.
- **Bubble:** all control bits 0 and `ALUOp` = 0. Register fields are don't-care but are driven to 0.
- **Load-use hazard:**
  - Condition: `Ex_MemRead` AND `Ex_Rt != 0` AND (`Ex_Rt == Id_Rs` OR `Ex_Rt == Id_Rt`).
  - Response: `Stall`=1; ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
- **Taken branch:**
  - Condition: `Ex_Branch` AND `Zero`.
  - Response: `Flush`=1; ID/EX loads a bubble; `Stall` is forced to 0.
  - Taken branch has priority over load-use.
- **Forwarding, per operand X ∈ {Rs, Rt} of ID/EX:**
  - 2'b10 if `Mem_RegWrite` AND `Mem_WriteReg != 0` AND `Mem_WriteReg == Ex_X`.
  - Otherwise 2'b01 if the same test holds against the WB stage.
  - Otherwise 2'b00.
  - EX/MEM wins over MEM/WB. Register `$0` is never forwarded.
- **Counter:** `StallCount` increments by 1 in every cycle where `Stall | Flush`, and holds at all-ones.

## Timing
- Reset: all stage registers load a bubble; every output is 0, including `StallCount`, `Stall`, `Flush`, `ForwardA/B` and `Wb_WriteReg`.
- `Rst_n` asserted mid-operation clears in-flight instructions immediately, with no drain.
- Latency, normal flow: ID → EX outputs after 1 edge, MEM after 2, WB after 3.
- `Stall`, `Flush`, `ForwardA/B`: combinational from the current stage registers and ID inputs; valid in the same cycle.
- A stall lasts exactly 1 cycle per load-use pair. The following cycle the load is in MEM, and the dependent instruction re-evaluates with `ForwardX`=2'b01 one cycle after that.
- A flush lasts 1 cycle. The wrong-path instruction in ID becomes a bubble in EX on the next edge.
- Stall and flush in the same cycle: flush only. The counter increments once.

## Structure
- Package `ctrl_pipe_pkg` holds:
  - ALU op constants (ADD=2, SUB=6, AND=0, OR=1, SLT=7, NOR=12, SLL=3).
  - Forward encodings (FWD_NONE=0, FWD_WB=1, FWD_MEM=2).
  - Control-word bundle width and bubble value.
- One sub-module, `hazard_detect`: purely combinational. Produces `Stall`, `Flush` and `ForwardA/B` from stage register contents. `ctrl_pipe` owns all flops and the counter.

## Test plan
- **Reset:** `Rst_n`=0 mid-stream → all outputs 0 immediately; after release, first ADD (`RegWrite`=1, `ALUOp`=2) reaches `Wb_RegWrite`=1 exactly 3 edges after entering ID.
- **Load-use:** LW to `$5` followed by ADD reading `$5` → `Stall`=1 for one cycle, bubble in EX, then `ForwardA`=2'b01 when the ADD is in EX; `StallCount`=1.
- **EX/MEM over MEM/WB priority:** ADD `$3`, ADD `$3`, then SUB reading `$3` → `ForwardA`=2'b10, not 01.
- **`$0` destination:** ADDI writing `$0` followed by a reader of `$0` → `ForwardA/B`=2'b00 and no stall, even when the writer is a LW.
- **Branch:** BEQ in EX with `Zero`=1 while a load-use condition is also present → `Flush`=1, `Stall`=0, EX bubble next cycle, counter +1. Same sequence with `Zero`=0 → no flush.
- **Saturation:** set `STALL_CNT_W`=2 and force 5 stall cycles → `StallCount` holds at 3.
